// File: rtl/fpu_div_round_pack.sv
// Divider back end: normalizes the raw quotient, rounds to nearest-even, handles
// overflow/flush-to-zero and special classes, packs binary32; 2-stage valid/ready.
module fpu_div_round_pack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [27:0] in_mant,
  input  logic        in_sticky,
  input  logic [1:0]  in_class,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags,
  input  logic        flag_clr,
  output logic [3:0]  flag_sticky
);

  localparam int unsigned EXP_W  = 10;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned RES_W  = 32;
  localparam int unsigned FLG_W  = 4;

  localparam logic [1:0] CLS_NORMAL = 2'b00;
  localparam logic [1:0] CLS_ZERO   = 2'b01;
  localparam logic [1:0] CLS_INF    = 2'b10;
  localparam logic [1:0] CLS_NAN    = 2'b11;

  localparam logic [RES_W-1:0] QNAN = 32'h7FC0_0000;

  logic              r_s1_valid;
  logic              r_s1_sign;
  logic [EXP_W-1:0]  r_s1_exp;
  logic [FRAC_W-1:0] r_s1_frac;
  logic              r_s1_guard;
  logic              r_s1_sticky;
  logic [1:0]        r_s1_class;

  logic              r_out_valid;
  logic [RES_W-1:0]  r_out_result;
  logic [FLG_W-1:0]  r_out_flags;
  logic [FLG_W-1:0]  r_flag_sticky;

  logic              w_s2_advance;
  logic              w_in_ready;
  logic [EXP_W-1:0]  w_n_exp;
  logic [FRAC_W-1:0] w_n_frac;
  logic              w_n_guard;
  logic              w_n_sticky;
  logic [1:0]        w_n_class;

  logic              w_round_up;
  logic [FRAC_W:0]   w_frac_rnd;
  logic [EXP_W-1:0]  w_exp_rnd;
  logic              w_inexact;
  logic [RES_W-1:0]  w_pk_result;
  logic [FLG_W-1:0]  w_pk_flags;

  assign w_s2_advance = ~r_out_valid | out_ready;
  assign w_in_ready   = ~r_s1_valid | w_s2_advance;

  // Normalize: pick the 24-bit window under the leading one (hidden bit dropped).
  always_comb begin
    w_n_exp    = in_exp;
    w_n_frac   = in_mant[25:3];
    w_n_guard  = in_mant[2];
    w_n_sticky = (|in_mant[1:0]) | in_sticky;
    w_n_class  = in_class;
    if (in_mant[27]) begin
      w_n_exp    = in_exp + EXP_W'(1);
      w_n_frac   = in_mant[26:4];
      w_n_guard  = in_mant[3];
      w_n_sticky = (|in_mant[2:0]) | in_sticky;
    end
    if ((in_class == CLS_NORMAL) && (in_mant[27:26] == 2'b00)) begin
      w_n_class = CLS_ZERO;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_exp    <= '0;
      r_s1_frac   <= '0;
      r_s1_guard  <= 1'b0;
      r_s1_sticky <= 1'b0;
      r_s1_class  <= CLS_ZERO;
    end else if (w_in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign   <= in_sign;
        r_s1_exp    <= w_n_exp;
        r_s1_frac   <= w_n_frac;
        r_s1_guard  <= w_n_guard;
        r_s1_sticky <= w_n_sticky;
        r_s1_class  <= w_n_class;
      end
    end
  end

  // Round to nearest-even; a carry past the hidden bit leaves fraction 0, exponent +1.
  always_comb begin
    w_round_up  = r_s1_guard & (r_s1_sticky | r_s1_frac[0]);
    w_frac_rnd  = {1'b0, r_s1_frac} + (FRAC_W+1)'(w_round_up);
    w_exp_rnd   = r_s1_exp + EXP_W'(w_frac_rnd[FRAC_W]);
    w_inexact   = r_s1_guard | r_s1_sticky;
    w_pk_result = '0;
    w_pk_flags  = '0;
    case (r_s1_class)
      CLS_NAN: begin
        w_pk_result = QNAN;
        w_pk_flags  = 4'b1000;
      end
      CLS_INF:  w_pk_result = {r_s1_sign, 8'hFF, 23'd0};
      CLS_ZERO: w_pk_result = {r_s1_sign, 31'd0};
      default: begin
        if ($signed(w_exp_rnd) >= $signed(10'sd255)) begin
          w_pk_result = {r_s1_sign, 8'hFF, 23'd0};
          w_pk_flags  = 4'b0101;
        end else if ($signed(w_exp_rnd) <= $signed(10'sd0)) begin
          w_pk_result = {r_s1_sign, 31'd0};
          w_pk_flags  = 4'b0011;
        end else begin
          w_pk_result = {r_s1_sign, w_exp_rnd[7:0], w_frac_rnd[FRAC_W-1:0]};
          w_pk_flags  = {3'b000, w_inexact};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_flags  <= '0;
    end else if (w_s2_advance) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_result <= w_pk_result;
        r_out_flags  <= w_pk_flags;
      end
    end
  end

  // Clear wins over history, but the flags of a coincident handshake still land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_sticky <= '0;
    end else if (flag_clr) begin
      r_flag_sticky <= (r_out_valid & out_ready) ? r_out_flags : '0;
    end else if (r_out_valid & out_ready) begin
      r_flag_sticky <= r_flag_sticky | r_out_flags;
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_result  = r_out_result;
  assign out_flags   = r_out_flags;
  assign flag_sticky = r_flag_sticky;

endmodule

// File: tb/tb_fpu_div_round_pack.sv
// Scoreboard bench for fpu_div_round_pack: expected results queued on accept,
// popped and compared when the output handshake occurs.
module tb_fpu_div_round_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [27:0] in_mant;
  logic        in_sticky;
  logic [1:0]  in_class;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic        flag_clr;
  logic [3:0]  flag_sticky;

  logic [35:0] sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        rand_ready = 1'b0;

  fpu_div_round_pack dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .in_sticky(in_sticky), .in_class(in_class),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .flag_clr(flag_clr), .flag_sticky(flag_sticky)
  );

  always #5 clk = ~clk;

  // Reference: integer shift-and-remainder rounding, independent of the RTL windowing.
  function automatic logic [35:0] model(input logic s, input logic [9:0] e,
                                        input logic [27:0] m, input logic st,
                                        input logic [1:0] c);
    int ex, sh;
    longint q, rem, half;
    logic inx, up;
    if (c == 2'b11) return {4'b1000, 32'h7FC00000};
    if (c == 2'b10) return {4'b0000, s, 8'hFF, 23'd0};
    if (c == 2'b01 || m[27:26] == 2'b00) return {4'b0000, s, 31'd0};
    ex   = int'($signed(e));
    sh   = m[27] ? 4 : 3;
    ex   = ex + sh - 3;
    q    = longint'(m) >> sh;
    rem  = longint'(m) % (longint'(1) << sh);
    half = longint'(1) << (sh - 1);
    inx  = (rem != 0) || st;
    up   = (rem > half) || ((rem == half) && (st || q[0]));
    q    = q + longint'(up);
    if (q == (longint'(1) << 24)) begin
      q  = q >> 1;
      ex = ex + 1;
    end
    if (ex >= 255) return {4'b0101, s, 8'hFF, 23'd0};
    if (ex <= 0) return {4'b0011, s, 31'd0};
    return {3'b000, inx, s, 8'(ex), q[22:0]};
  endfunction

  // Output monitor: samples on the falling edge, where the pending handshake is stable.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got result=%h flags=%b, required no output", out_result, out_flags);
      end else begin
        logic [35:0] ex;
        ex = sb.pop_front();
        if ({out_flags, out_result} !== ex) begin
          n_err++;
          $display("FAIL output: got result=%h flags=%b, required result=%h flags=%b",
                   out_result, out_flags, ex[31:0], ex[35:32]);
        end
      end
    end
  end

  task automatic set_in(input logic s, input logic [9:0] e, input logic [27:0] m,
                        input logic st, input logic [1:0] c);
    in_sign = s; in_exp = e; in_mant = m; in_sticky = st; in_class = c;
  endtask

  task automatic send(input logic s, input logic [9:0] e, input logic [27:0] m,
                      input logic st, input logic [1:0] c, input logic [35:0] ex);
    bit done = 0;
    int cyc = 0;
    set_in(s, e, m, st, c);
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        sb.push_back(ex);
        done = 1;
      end else begin
        @(posedge clk);
        cyc++;
        if (cyc > 200) begin
          n_cmp++; n_err++;
          $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, required accept", cyc);
          done = 1;
        end
      end
      #1;
      if (rand_ready) out_ready = 1'($urandom);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d outputs outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flag_clr = 1'b0;
    set_in(1'b0, 10'd0, 28'd0, 1'b0, 2'b00);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_result, out_flags, flag_sticky} !== 41'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b r=%h f=%b fs=%b, required all 0",
               out_valid, out_result, out_flags, flag_sticky);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    send(1'b0, 10'd127, 28'h4000000, 1'b0, 2'b00, {4'b0000, 32'h3F800000});
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL latency_early: got out_valid=%b one cycle after accept, required 0", out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL latency: got out_valid=%b two cycles after accept, required 1", out_valid);
    end
    drain();
  endtask

  task automatic test_rounding();
    send(1'b0, 10'd127, 28'h8000000, 1'b0, 2'b00, {4'b0000, 32'h40000000});
    send(1'b0, 10'd127, 28'h7FFFFFC, 1'b0, 2'b00, {4'b0001, 32'h40000000});
    send(1'b0, 10'd127, 28'h4000004, 1'b0, 2'b00, {4'b0001, 32'h3F800000});
    send(1'b0, 10'd127, 28'h400000C, 1'b0, 2'b00, {4'b0001, 32'h3F800002});
    send(1'b1, 10'd127, 28'h4000004, 1'b1, 2'b00, {4'b0001, 32'hBF800001});
    send(1'b0, 10'd300, 28'h4000000, 1'b0, 2'b00, {4'b0101, 32'h7F800000});
    send(1'b1, 10'(-5), 28'h4000000, 1'b0, 2'b00, {4'b0011, 32'h80000000});
    send(1'b0, 10'd254, 28'h7FFFFFC, 1'b0, 2'b00, {4'b0101, 32'h7F800000});
    send(1'b0, 10'd1, 28'h4000000, 1'b0, 2'b00, {4'b0000, 32'h00800000});
    send(1'b0, 10'd0, 28'h4000000, 1'b0, 2'b00, {4'b0011, 32'h00000000});
    drain();
  endtask

  task automatic test_specials();
    send(1'b0, 10'd127, 28'h4000000, 1'b0, 2'b11, {4'b1000, 32'h7FC00000});
    send(1'b1, 10'd5, 28'h0, 1'b0, 2'b10, {4'b0000, 32'hFF800000});
    send(1'b0, 10'd300, 28'h4000000, 1'b1, 2'b01, {4'b0000, 32'h00000000});
    send(1'b1, 10'd127, 28'h1000000, 1'b0, 2'b00, {4'b0000, 32'h80000000});
    drain();
  endtask

  task automatic test_backpressure();
    logic [27:0] mant [4] = '{28'h4000000, 28'h8000000, 28'h6000000, 28'h5000000};
    logic [31:0] res  [4] = '{32'h3F800000, 32'h40000000, 32'h3FC00000, 32'h3FA00000};
    int idx = 0;
    int cyc = 0;
    bit acc;
    out_ready = 1'b0;
    set_in(1'b0, 10'd127, mant[0], 1'b0, 2'b00);
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc = in_ready && idx < 4;
      @(posedge clk);
      if (acc) begin sb.push_back({4'b0000, res[idx]}); idx++; end
      #1;
      if (idx < 4) in_mant = mant[idx]; else in_valid = 1'b0;
    end
    n_cmp++;
    if (idx != 2) begin
      n_err++;
      $display("FAIL bp_accept_count: got %0d accepted, required 2", idx);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== res[0]) begin
        n_err++;
        $display("FAIL bp_hold: got in_ready=%b out_valid=%b result=%h, required 0 1 %h",
                 in_ready, out_valid, out_result, res[0]);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    while (idx < 4 && cyc < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      if (acc) begin sb.push_back({4'b0000, res[idx]}); idx++; end
      #1;
      if (idx < 4) in_mant = mant[idx]; else in_valid = 1'b0;
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (idx != 4) begin
      n_err++;
      $display("FAIL bp_release: got %0d accepted, required 4", idx);
    end
    drain();
  endtask

  task automatic test_flags();
    int cyc = 0;
    flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    n_cmp++;
    if (flag_sticky !== 4'b0000) begin
      n_err++;
      $display("FAIL flag_clear_idle: got %b, required 0000", flag_sticky);
    end
    send(1'b0, 10'd300, 28'h4000000, 1'b0, 2'b00, {4'b0101, 32'h7F800000});
    send(1'b0, 10'd1, 28'h4000000, 1'b0, 2'b11, {4'b1000, 32'h7FC00000});
    drain();
    @(posedge clk); #1;
    n_cmp++;
    if (flag_sticky !== 4'b1101) begin
      n_err++;
      $display("FAIL flag_accum: got %b, required 1101", flag_sticky);
    end
    out_ready = 1'b0;
    send(1'b0, 10'd127, 28'h4000004, 1'b0, 2'b00, {4'b0001, 32'h3F800000});
    while (!out_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    flag_clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    n_cmp++;
    if (flag_sticky !== 4'b0001) begin
      n_err++;
      $display("FAIL flag_clr_handshake: got %b, required 0001", flag_sticky);
    end
    drain();
  endtask

  task automatic test_random();
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic s, st;
      logic [9:0] e;
      logic [27:0] m;
      logic [1:0] c;
      s  = 1'($urandom);
      st = 1'($urandom);
      e  = 10'($urandom_range(0, 532) - 150);
      m  = 28'($urandom);
      if ($urandom_range(0, 1) == 0) m[27] = 1'b1;
      else begin m[27] = 1'b0; m[26] = 1'b1; end
      c  = ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom_range(1, 3));
      send(s, e, m, st, c, model(s, e, m, st, c));
    end
    rand_ready = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(1'b0, 10'd300, 28'h4000000, 1'b0, 2'b00, {4'b0101, 32'h7F800000});
    send(1'b0, 10'd127, 28'h4000000, 1'b0, 2'b00, {4'b0000, 32'h3F800000});
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_result, out_flags, flag_sticky} !== 41'd0) begin
      n_err++;
      $display("FAIL reset_mid: got v=%b r=%h f=%b fs=%b, required all 0",
               out_valid, out_result, out_flags, flag_sticky);
    end
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(1'b1, 10'd128, 28'h8000000, 1'b0, 2'b00, {4'b0000, 32'hC0800000});
    drain();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_rounding();
    test_specials();
    test_backpressure();
    test_flags();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_div_round_pack.md
# fpu_div_round_pack

Downstream stage of the single-precision divider datapath. Accepts the raw quotient (sign, pre-normalization biased exponent, extended mantissa with guard/sticky information, special-case class) and normalizes, rounds to nearest-even, handles overflow/underflow and special operands, then packs an IEEE-754 binary32 result. It is a 2-stage valid/ready pipeline with an accumulating exception-flag register, sitting between the divider core and the FPU result writeback.

## Interface

- No parameters.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream result valid
- in_ready  out  1  stage can accept (combinational from out_ready)
- in_sign  in  1  result sign (A sign XOR B sign)
- in_exp  in  10  two's-complement biased exponent before normalization (expA − expB + 127)
- in_mant  in  28  quotient significand; leading one at bit 27 or bit 26, lower bits fraction
- in_sticky  in  1  nonzero division remainder
- in_class  in  2  00 normal, 01 zero, 10 infinity, 11 NaN
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_result  out  32  packed binary32 result
- out_flags  out  4  {invalid, overflow, underflow, inexact} for out_result
- flag_clr  in  1  synchronous clear of flag_sticky
- flag_sticky  out  4  OR of out_flags over all completed output handshakes

## Operation

- Stage 1 (normalize), registered:
  - in_mant[27]=1: sig = in_mant[27:4], guard = in_mant[3], sticky = |in_mant[2:0] | in_sticky, exp = in_exp + 1.
  - else in_mant[26]=1: sig = in_mant[26:3], guard = in_mant[2], sticky = |in_mant[1:0] | in_sticky, exp = in_exp.
  - class normal with in_mant[27:26]=00: treated as class zero, flags 0.
- Stage 2 (round/pack), registered into out_result/out_flags:
  - round_up = guard & (sticky | sig[0]); sig24 + round_up; carry out of bit 23 → sig = 24'h800000, exp + 1.
  - inexact = guard | sticky.
  - exp ≥ 255 (after rounding): {sign, 8'hFF, 23'd0}, flags overflow|inexact.
  - exp ≤ 0: flush to {sign, 31'd0} (no subnormals), flags underflow|inexact.
  - else {sign, exp[7:0], sig[22:0]}, flags {0,0,0,inexact}.
- Specials bypass rounding: zero → {sign,31'd0}, flags 0; infinity → {sign,8'hFF,23'd0}, flags 0; NaN → 32'h7FC00000, flags invalid.
- Exponent arithmetic is 10-bit signed throughout; no wrap for inputs in −150..+382.
- flag_sticky: on out_valid & out_ready, flag_sticky |= out_flags. flag_clr clears first; if coincident with a handshake, result = out_flags of that handshake.

## Timing

- Reset (async assert, sync-safe deassert): stage valids 0, out_valid 0, out_result 32'd0, out_flags 0, flag_sticky 0. Reset mid-operation discards in-flight items.
- Transfer on in_valid & in_ready at edge N → stage 1 at N; out_valid high after edge N+1. Latency 2 cycles; throughput 1/cycle with out_ready held 1.
- s2_advance = ~out_valid | out_ready; in_ready = ~s1_valid | s2_advance.
- While out_valid & ~out_ready: out_result, out_flags held stable; stage 1 holds; at most 2 items buffered, then in_ready = 0.
- Order preserved; no item dropped or duplicated under any in_valid/out_ready pattern.
- flag_clr effective at next edge regardless of handshake state.

## Test plan

- in_class=00, sign 0, in_exp=127, in_mant=28'h4000000, in_sticky 0 → out_result 32'h3F800000, out_flags 0, out_valid 2 cycles after accept.
- in_mant=28'h8000000, in_exp=127 → 32'h40000000 (exponent increment); in_mant=28'h7FFFFFC, in_exp=127 → rounding carry → 32'h40000000, out_flags 4'b0001; in_mant=28'h4000004 → tie-to-even, 32'h3F800000, inexact.
- in_exp=300 → 32'h7F800000, flags 4'b0101; in_exp=−5, sign 1 → 32'h80000000, flags 4'b0011.
- Class NaN → 32'h7FC00000, flags 4'b1000; class inf sign 1 → 32'hFF800000, flags 0; class zero → 32'h00000000.
- Backpressure: out_ready=0, 4 back-to-back inputs → exactly 2 accepted then in_ready=0, out_result stable; release out_ready → remaining accepted, all 4 outputs in order.
- flag_sticky accumulates overflow then invalid → 4'b1101; flag_clr asserted on the cycle of an inexact-only handshake → 4'b0001; rst_n pulse mid-stream → all outputs 0 immediately.
